// File: rtl/simple_8bit_adder_if.sv
// Bus bundle for simple_8bit_adder: operands, capture strobe, combinational and registered results.
// Ports: master drives a/b/c_in/in_valid and reads results; slave (the adder) does the reverse.
// Optional flag outputs ovf_q/zero_q/neg_q exist only when SIMPLE_8BIT_ADDER_FLAGS_EN is defined.
interface simple_8bit_adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             out_valid;
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
`endif

  modport master (
    output a, b, c_in, in_valid,
    input  s, c_out, s_q, c_out_q, out_valid
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
    , input ovf_q, zero_q, neg_q
`endif
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output s, c_out, s_q, c_out_q, out_valid
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
    , output ovf_q, zero_q, neg_q
`endif
  );
endinterface

// File: rtl/simple_8bit_adder.sv
// Purpose: ripple-carry adder {c_out,s} = a+b+c_in with a registered copy and valid strobe.
// Latency: s/c_out combinational; s_q/c_out_q/out_valid one clk after in_valid.
// Backpressure: none, every in_valid strobe is captured.
// Ports: clk, rst (async, active-high); bus (slave modport) carries a, b, c_in, in_valid,
//        s, c_out, s_q, c_out_q, out_valid.
// Optional: define SIMPLE_8BIT_ADDER_FLAGS_EN to add registered ovf_q, zero_q, neg_q.
module simple_8bit_adder #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  simple_8bit_adder_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // Ripple chain of full-adder cells; carry[0] is the carry-in, carry[WIDTH] the carry-out.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = bus.c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
    end
  end

  assign bus.s     = sum;
  assign bus.c_out = carry[WIDTH];

  logic [WIDTH-1:0] sum_d,  sum_q;
  logic             cout_d, cout_q;
  logic             vld_d,  vld_q;
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
  logic             ovf_d,  ovf_q;
  logic             zero_d, zero_q;
  logic             neg_d,  neg_q;
`endif

  // Result registers hold between strobes; the valid strobe is a pure one-cycle echo.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = bus.in_valid;
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
    ovf_d  = ovf_q;
    zero_d = zero_q;
    neg_d  = neg_q;
`endif
    if (bus.in_valid) begin
      sum_d  = sum;
      cout_d = carry[WIDTH];
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
      // Signed overflow: operands share a sign that the result does not.
      ovf_d  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      zero_d = (sum == '0);
      neg_d  = sum[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
`endif
    end
  end

  assign bus.s_q       = sum_q;
  assign bus.c_out_q   = cout_q;
  assign bus.out_valid = vld_q;
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
  assign bus.ovf_q     = ovf_q;
  assign bus.zero_q    = zero_q;
  assign bus.neg_q     = neg_q;
`endif

endmodule

// File: tb/tb_simple_8bit_adder.sv
// Directed bench for simple_8bit_adder: comb results, registered capture, async reset, sweeps.
module tb_simple_8bit_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  simple_8bit_adder_if #(.WIDTH(8)) bus ();

  simple_8bit_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic vld);
    bus.a        = av;
    bus.b        = bv;
    bus.c_in     = ci;
    bus.in_valid = vld;
  endtask

  initial begin
    int          bad;
    logic [8:0]  e;
    logic [8:0]  first_obs;
    logic [8:0]  first_exp;
    logic [8:0]  pend;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    check("rst_s_q",       {1'b0, bus.s_q},  9'h000);
    check("rst_c_out_q",   {8'h00, bus.c_out_q}, 9'h000);
    check("rst_out_valid", {8'h00, bus.out_valid}, 9'h000);

    // Combinational path works while reset is held.
    drive(8'h0A, 8'h05, 1'b0, 1'b0);
    #1;
    check("comb_0a_05_in_rst", {bus.c_out, bus.s}, 9'h00F);

    tick();
    #4;
    rst = 1'b0;
    tick();

    // 0x0A + 0x05 capture
    drive(8'h0A, 8'h05, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("reg_0a_05_sum", {bus.c_out_q, bus.s_q}, 9'h00F);
    check("reg_0a_05_vld", {8'h00, bus.out_valid}, 9'h001);
    tick();
    check("vld_drops", {8'h00, bus.out_valid}, 9'h000);
    check("s_q_holds", {bus.c_out_q, bus.s_q}, 9'h00F);

    // Wrap-around
    drive(8'hFF, 8'hFF, 1'b0, 1'b0);
    #1;
    check("comb_ff_ff_0", {bus.c_out, bus.s}, 9'h1FE);
    bus.c_in = 1'b1;
    #1;
    check("comb_ff_ff_1", {bus.c_out, bus.s}, 9'h1FF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("reg_ff_ff_1", {bus.c_out_q, bus.s_q}, 9'h1FF);

    // Full carry ripple
    drive(8'hFF, 8'h00, 1'b1, 1'b1);
    #1;
    check("comb_ff_00_1", {bus.c_out, bus.s}, 9'h100);
    tick();
    bus.in_valid = 1'b0;
    check("reg_ff_00_1", {bus.c_out_q, bus.s_q}, 9'h100);
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
    check("zero_ff_00_1", {8'h00, bus.zero_q}, 9'h001);
    check("ovf_ff_00_1",  {8'h00, bus.ovf_q},  9'h000);
    check("neg_ff_00_1",  {8'h00, bus.neg_q},  9'h000);
`endif

    // Signed overflow into the sign bit
    drive(8'h7F, 8'h01, 1'b0, 1'b1);
    #1;
    check("comb_7f_01", {bus.c_out, bus.s}, 9'h080);
    tick();
    bus.in_valid = 1'b0;
    check("reg_7f_01", {bus.c_out_q, bus.s_q}, 9'h080);
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
    check("ovf_7f_01",  {8'h00, bus.ovf_q},  9'h001);
    check("neg_7f_01",  {8'h00, bus.neg_q},  9'h001);
    check("zero_7f_01", {8'h00, bus.zero_q}, 9'h000);
`endif

    // Capture 0x10+0x20, then assert reset mid-cycle.
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    tick();
    check("reg_10_20", {bus.c_out_q, bus.s_q}, 9'h030);
    check("reg_10_20_vld", {8'h00, bus.out_valid}, 9'h001);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_s_q", {bus.c_out_q, bus.s_q}, 9'h000);
    check("async_rst_vld", {8'h00, bus.out_valid}, 9'h000);
`ifdef SIMPLE_8BIT_ADDER_FLAGS_EN
    check("async_rst_flags", {6'h00, bus.ovf_q, bus.zero_q, bus.neg_q}, 9'h000);
`endif
    // Strobe still high across an edge while reset is held: must be discarded.
    tick();
    check("rst_hold_s_q", {bus.c_out_q, bus.s_q}, 9'h000);
    check("rst_hold_vld", {8'h00, bus.out_valid}, 9'h000);

    bus.in_valid = 1'b0;
    #4;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_vld", {8'h00, bus.out_valid}, 9'h000);
      check("idle_s_q", {bus.c_out_q, bus.s_q}, 9'h000);
    end

    // First capture after release
    drive(8'h80, 8'h80, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("first_after_rst", {bus.c_out_q, bus.s_q}, 9'h101);
    check("first_after_rst_vld", {8'h00, bus.out_valid}, 9'h001);

    // Exhaustive combinational sweep, one aggregated comparison.
    bad = 0;
    first_obs = '0;
    first_exp = '0;
    for (int ci = 0; ci < 2; ci++) begin
      for (int ai = 0; ai < 256; ai++) begin
        for (int bi = 0; bi < 256; bi++) begin
          bus.a    = ai[7:0];
          bus.b    = bi[7:0];
          bus.c_in = ci[0];
          #1;
          e = 9'(ai + bi + ci);
          if ({bus.c_out, bus.s} !== e) begin
            if (bad == 0) begin
              first_obs = {bus.c_out, bus.s};
              first_exp = e;
            end
            bad++;
          end
        end
      end
    end
    check("sweep_first_bad", first_obs, first_exp);
    check("sweep_bad_count", bad[8:0], 9'h000);

    // Back-to-back registered strobes, each checked one cycle later.
    bad = 0;
    first_obs = '0;
    first_exp = '0;
    @(posedge clk);
    #1;
    drive(8'h00, 8'h0B, 1'b0, 1'b1);
    pend = 9'h00B;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if ({bus.c_out_q, bus.s_q} !== pend || bus.out_valid !== 1'b1) begin
        if (bad == 0) begin
          first_obs = {bus.c_out_q, bus.s_q};
          first_exp = pend;
        end
        bad++;
      end
      bus.a    = 8'(k);
      bus.b    = 8'(k * 37 + 11);
      bus.c_in = k[0];
      pend     = 9'((k & 255) + ((k * 37 + 11) & 255) + (k & 1));
    end
    bus.in_valid = 1'b0;
    check("reg_sweep_first_bad", first_obs, first_exp);
    check("reg_sweep_bad_count", bad[8:0], 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_8bit_adder.md
Name: simple_8bit_adder

Overview:
- 8-bit binary adder with carry-in and carry-out. Basic arithmetic primitive of the 8-bit datapath (ALU and address increment paths).
- Sum and carry are available combinationally, built as a ripple chain of eight full-adder bit cells.
- A registered copy of the result, with a valid strobe, is provided for pipelined consumers.

Parameters:
- WIDTH, 8, operand/sum width; only 8 is required to be supported.

Ports:
- clk  input  1  rising-edge clock for the registered result
- rst  input  1  asynchronous, active-high reset
- a  input  8  operand A (unsigned or two's complement)
- b  input  8  operand B
- c_in  input  1  carry-in, weight 1
- in_valid  input  1  capture strobe for the registered result
- s  output  8  combinational sum, low 8 bits of a+b+c_in
- c_out  output  1  combinational carry-out, bit 8 of a+b+c_in
- s_q  output  8  registered sum
- c_out_q  output  1  registered carry-out
- out_valid  output  1  high one cycle after an accepted in_valid

Behaviour:
- Combinational path:
  - {c_out, s} = a + b + c_in, exact 9-bit result.
  - No clock involvement; settles within one propagation delay of any input change.
  - Independent of rst.
- Ripple structure:
  - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = c_in; c_out = c[8].
- Wrap-around: results above 255 wrap modulo 256 and set c_out. Example: 0xFF+0xFF+0 gives s=0xFE, c_out=1.
- Registered path:
  - On each rising clk edge with in_valid=1: s_q<=s, c_out_q<=c_out, out_valid<=1.
  - On each rising clk edge with in_valid=0: s_q and c_out_q hold; out_valid<=0.
  - Latency is 1 cycle. No backpressure; every strobe is accepted.
- Reset:
  - rst=1 immediately forces s_q=0x00, c_out_q=0, out_valid=0, regardless of clk.
  - The registered outputs remain in that state while rst is high.
  - Deassertion: the first capture happens on the first rising edge with rst=0 and in_valid=1.
  - A capture in flight when rst asserts is discarded.
- X-handling: not required; inputs are assumed driven when in_valid=1.

Optional Feature:
- Macro SIMPLE_8BIT_ADDER_FLAGS_EN.
- When defined, the block adds registered status outputs, captured with s_q and cleared to 0 by rst:
  - ovf_q (1 bit): signed overflow, a[7]==b[7] && s[7]!=a[7].
  - zero_q (1 bit): s==0x00.
  - neg_q (1 bit): s[7].
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- a=0x0A, b=0x05, c_in=0 -> s=0x0F, c_out=0 after settle; with in_valid pulsed, s_q=0x0F, c_out_q=0, out_valid=1 one cycle later.
- a=0xFF, b=0xFF, c_in=0 -> s=0xFE, c_out=1; with c_in=1 -> s=0xFF, c_out=1.
- a=0xFF, b=0x00, c_in=1 -> s=0x00, c_out=1 (full carry ripple). With FLAGS_EN: zero_q=1, ovf_q=0.
- a=0x7F, b=0x01, c_in=0 -> s=0x80, c_out=0. With FLAGS_EN: ovf_q=1, neg_q=1.
- Capture a=0x10, b=0x20; assert rst mid-cycle -> s_q=0x00, c_out_q=0, out_valid=0 immediately, without waiting for a clk edge.
- After rst release, hold in_valid=0 for 3 cycles -> out_valid stays 0 and s_q stays 0x00.
- Exhaustive sweep of all a, b, c_in combinations -> {c_out, s} equals a+b+c_in; s_q matches one cycle after each strobe.
